// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one 11-bit adder among N_REQ requesters, with a
// single registered response slot. Optional grant/stall counters: ADDER_RR_SCHED_STATS_EN.
module adder_11bit (
  input  logic [10:0] a,
  input  logic [10:0] b,
  input  logic        cin,
  output logic [11:0] sum
);
  assign sum = {1'b0, a} + {1'b0, b} + {11'd0, cin};
endmodule

module adder_rr_sched #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [11*N_REQ-1:0]  req_a,
  input  logic [11*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [11:0]          rsp_sum,
  output logic [2:0]           rsp_id
`ifdef ADDER_RR_SCHED_STATS_EN
  ,
  output logic [15:0]          grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);
  localparam logic [3:0] NR = 4'(N_REQ);

  typedef enum logic {EMPTY, FULL} state_t;
  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [11:0] sum_q, sum_d;
  logic [2:0]  id_q, id_d;

  logic        slot_free, grant, rsp_fire;
  logic [2:0]  gnt_id;
  logic [3:0]  scan_idx, nxt_idx;
  logic [7:0]  req_ext, rdy_ext;
  logic [10:0] op_a, op_b;
  logic [11:0] add_sum;

  assign rsp_fire  = rsp_valid && rsp_ready;
  assign slot_free = !rsp_valid || rsp_ready;

  // Scan from the farthest offset down so the first valid index after ptr wins last.
  always_comb begin
    grant    = 1'b0;
    gnt_id   = 3'd0;
    scan_idx = 4'd0;
    req_ext  = 8'd0;
    req_ext[N_REQ-1:0] = req_valid;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + 4'(k);
      if (scan_idx >= NR) scan_idx = scan_idx - NR;
      if (req_ext[scan_idx[2:0]]) begin
        grant  = 1'b1;
        gnt_id = scan_idx[2:0];
      end
    end
    if (!slot_free || rst) grant = 1'b0;
    rdy_ext   = grant ? (8'd1 << gnt_id) : 8'd0;
    req_ready = rdy_ext[N_REQ-1:0];
  end

  assign op_a = req_a[11*gnt_id +: 11];
  assign op_b = req_b[11*gnt_id +: 11];

  adder_11bit u_add (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (add_sum)
  );

  always_comb begin
    nxt_idx = {1'b0, gnt_id} + 4'd1;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (grant) begin
      ptr_d = (nxt_idx >= NR) ? 3'd0 : nxt_idx[2:0];
      sum_d = add_sum;
      id_d  = gnt_id;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (rsp_fire && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 3'd0;
      sum_q   <= 12'd0;
      id_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
    rsp_sum   = sum_q;
    rsp_id    = id_q;
  end

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant && grant_cnt_q != 16'hFFFF) grant_cnt_d = grant_cnt_q + 16'd1;
    if (rsp_valid && !rsp_ready && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_adder_rr_sched.sv
// Scoreboard bench for adder_rr_sched: stimulus pushes expected {id,sum}, a
// negedge monitor pops on every response transfer.
module tb_adder_rr_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'd0;
  logic [43:0] req_a = 44'd0;
  logic [43:0] req_b = 44'd0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [11:0] rsp_sum;
  logic [2:0]  rsp_id;
`ifdef ADDER_RR_SCHED_STATS_EN
  logic [15:0] grant_cnt, stall_cnt;
  int n_grant = 0, n_stall = 0;
`endif

  int total = 0;
  int bad = 0;
  logic [14:0] sb[$];

  always #5 clk = ~clk;

  adder_rr_sched #(.N_REQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id)
`ifdef ADDER_RR_SCHED_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h with empty scoreboard", rsp_id, rsp_sum);
      end else begin
        logic [14:0] e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[14:12]));
        chk("rsp_sum", 32'(rsp_sum), 32'(e[11:0]));
      end
    end
`ifdef ADDER_RR_SCHED_STATS_EN
    if (!rst && rsp_valid && !rsp_ready) n_stall++;
`endif
  end

  task automatic set_op(input int i, input logic [10:0] a, input logic [10:0] b);
    req_a[11*i +: 11] = a;
    req_b[11*i +: 11] = b;
  endtask

  // One cycle: drive valid, check req_ready at negedge, push expectation on grant.
  task automatic issue(input logic [3:0] v, input logic [3:0] exp_rdy,
                       input logic [2:0] exp_id, input logic [11:0] exp_sum);
    req_valid = v;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != 4'd0) begin
      sb.push_back({exp_id, exp_sum});
`ifdef ADDER_RR_SCHED_STATS_EN
      n_grant++;
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
`ifdef ADDER_RR_SCHED_STATS_EN
    n_grant = 0; n_stall = 0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    req_valid = 4'b1111;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request, then carry cases from requester 2.
    set_op(0, 11'h005, 11'h003);
    issue(4'b0001, 4'b0001, 3'd0, 12'h008);
    issue(4'b0000, 4'b0000, 3'd0, 12'h000);
    set_op(2, 11'h7FF, 11'h001);
    issue(4'b0100, 4'b0100, 3'd2, 12'h800);
    set_op(2, 11'h7FF, 11'h7FF);
    issue(4'b0100, 4'b0100, 3'd2, 12'hFFE);
    issue(4'b0000, 4'b0000, 3'd0, 12'h000);

    // Backpressure: hold a result for 3 cycles, then pass-through grant.
    set_op(0, 11'h010, 11'h001);
    set_op(1, 11'h020, 11'h002);
    set_op(2, 11'h030, 11'h003);
    set_op(3, 11'h040, 11'h004);
    issue(4'b0010, 4'b0010, 3'd1, 12'h022);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      issue(4'b1000, 4'b0000, 3'd0, 12'h000);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_sum", 32'(rsp_sum), 32'h022);
      chk("stall_id", 32'(rsp_id), 32'd1);
    end
    rsp_ready = 1'b1;
    issue(4'b1000, 4'b1000, 3'd3, 12'h044);
    issue(4'b0000, 4'b0000, 3'd0, 12'h000);

`ifdef ADDER_RR_SCHED_STATS_EN
    @(negedge clk);
    chk("grant_cnt", 32'(grant_cnt), 32'(n_grant));
    chk("stall_cnt", 32'(stall_cnt), 32'(n_stall));
    chk("grant_cnt_const", 32'(grant_cnt), 32'd5);
    chk("stall_cnt_const", 32'(stall_cnt), 32'd3);
    @(posedge clk); #1;
`endif

    // Async reset while a result is pending; ptr is 0 here after the wrap from 3.
    issue(4'b0010, 4'b0010, 3'd1, 12'h022);
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    #2;
    rst = 1'b1;
    sb.delete();
`ifdef ADDER_RR_SCHED_STATS_EN
    n_grant = 0; n_stall = 0;
`endif
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    issue(4'b1100, 4'b0100, 3'd2, 12'h033);
    issue(4'b0000, 4'b0000, 3'd0, 12'h000);

    // Round-robin from reset with all requesters valid.
    do_reset();
    issue(4'b1111, 4'b0001, 3'd0, 12'h011);
    issue(4'b1111, 4'b0010, 3'd1, 12'h022);
    issue(4'b1111, 4'b0100, 3'd2, 12'h033);
    issue(4'b1111, 4'b1000, 3'd3, 12'h044);
    issue(4'b1111, 4'b0001, 3'd0, 12'h011);
    issue(4'b1111, 4'b0010, 3'd1, 12'h022);
    issue(4'b0000, 4'b0000, 3'd0, 12'h000);
    @(negedge clk);
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler that time-shares one adder_11bit instance among N_REQ requesters.
- Each requester presents an 11-bit operand pair on a valid/ready handshake. The scheduler grants at most one request per cycle.
- The granted operands go into the shared adder. The 12-bit sum and the winning requester ID are registered into a single response slot with backpressure.
- Sits between operand producers and downstream result consumers wherever adder hardware is too costly to replicate.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester request valid
- req_a  input  11*N_REQ  operand A, requester i at bits [11*i+10:11*i]
- req_b  input  11*N_REQ  operand B, same packing as req_a
- req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle
- rsp_valid  output  1  response slot holds a result
- rsp_ready  input  1  downstream accepts response
- rsp_sum  output  12  registered a+b of the granted request, carry in bit 11
- rsp_id  output  3  index of the requester that produced rsp_sum; upper unused bits 0

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, rr pointer ptr=0, all counters 0.
  - req_ready=0 while rst is asserted.
- Slot-free condition: slot_free = !rsp_valid || rsp_ready.
  - Same-cycle pass-through is allowed: a response consumed this cycle frees the slot for a new grant in the same cycle.
- Arbitration (combinational):
  - When slot_free, scan req_valid starting at index ptr, ascending, wrapping at N_REQ-1 to 0.
  - The first asserted index g gets req_ready[g]=1.
  - When !slot_free, req_ready is all 0.
- req_ready depends on req_valid, ptr and the slot state only. Requesters must not make req_valid depend on req_ready.
- Transfer on requester i: req_valid[i] && req_ready[i] at a rising edge.
- Transfer on the response side: rsp_valid && rsp_ready.
- Datapath:
  - A mux selects req_a/req_b of g into the single shared adder_11bit (cin fixed 0).
  - Result width is 12 bits, unsigned, with no truncation. Example: 0x7FF+0x7FF=0xFFE.
- Slot update at the edge:
  - On a grant: rsp_sum <= adder output, rsp_id <= g, rsp_valid <= 1, ptr <= (g+1) mod N_REQ.
  - Else if a response transfer occurs: rsp_valid <= 0, and rsp_sum/rsp_id hold their values.
  - Else: all hold.
- Latency: one cycle from request transfer to rsp_valid. Throughput: one result per cycle when rsp_ready is held at 1.
- Stability: while rsp_valid=1 && rsp_ready=0, rsp_sum and rsp_id are held stable.
- Two-state slot FSM:
  - EMPTY -> FULL on grant.
  - FULL -> FULL on response transfer together with a grant.
  - FULL -> EMPTY on response transfer with no grant.
  - FULL holds on stall.
- No requests: ptr holds.
- Fairness: a requester holding req_valid is granted within N_REQ grants.
- Reset mid-operation: a pending result is discarded, with no response emitted after release. Arbitration resumes from ptr=0 on the first cycle after rst deasserts.

Optional Feature:
- Macro: ADDER_RR_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt (16 bits): total grants, saturating at 0xFFFF.
  - Adds output stall_cnt (16 bits): cycles with rsp_valid && !rsp_ready, saturating at 0xFFFF.
  - Both counters reset to 0.
- When undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Single request: req_valid=4'b0001, a0=0x005, b0=0x003 → req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_sum=0x008, rsp_id=0.
- Overflow carry: requester 2 sends a=0x7FF, b=0x001 → rsp_sum=0x800, rsp_id=2. Repeat with a=b=0x7FF → rsp_sum=0xFFE.
- Round-robin: all four valid continuously, rsp_ready=1, from reset → grant/rsp_id order 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure:
  - rsp_ready=0 for 3 cycles with a result held → rsp_sum/rsp_id stable, req_ready=0 throughout.
  - rsp_ready=1 → response transfer and a new grant in the same cycle.
- Async reset mid-operation: assert rst between clock edges while rsp_valid=1 → rsp_valid=0 immediately. After release, with req_valid=4'b1100, the first grant goes to requester 2 (ptr=0).
- With ADDER_RR_SCHED_STATS_EN: 5 grants plus 3 stall cycles → grant_cnt=5, stall_cnt=3. Force grant_cnt to 0xFFFF → it stays at 0xFFFF on further grants.
